// File: rtl/mult_stream_ctrl_if.sv
// Operand/result stream bundle for mult_stream_ctrl.
// The slave modport is the controller's view; the master modport is the producer/consumer side.
interface mult_stream_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_mr;
    logic [WIDTH-1:0]     in_mc;
    logic [TAGW-1:0]      in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_prod;
    logic [TAGW-1:0]      out_tag;

    modport master (
        output in_valid, in_mr, in_mc, in_tag, out_ready,
        input  in_ready, out_valid, out_prod, out_tag
    );

    modport slave (
        input  in_valid, in_mr, in_mc, in_tag, out_ready,
        output in_ready, out_valid, out_prod, out_tag
    );
endinterface

// File: rtl/mult_stream_ctrl.sv
// Streaming wrapper around a fixed-latency multiplier core: feeds operands, tracks
// in-flight operations with a valid/tag pipeline and queues products in a show-ahead FIFO.
module mult_stream_ctrl #(
    parameter int WIDTH = 32,
    parameter int LAT   = 2,
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_stream_ctrl_if.slave    bus,
    output logic [WIDTH-1:0]     MR,
    output logic [WIDTH-1:0]     MC,
    input  logic [2*WIDTH-1:0]   Prod,
    output logic                 busy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 2*WIDTH + TAGW;

    logic [LAT-1:0]   vld_q, vld_d;
    logic [TAGW-1:0]  tag_q [LAT];
    logic [TAGW-1:0]  tag_d [LAT];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [EW-1:0]    mem [DEPTH];

    logic             accept;
    logic             wr_en;
    logic             pop;
    logic [31:0]      inflight;
    logic [31:0]      occupancy;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + 32'(vld_q[i]);
        end
    end

    // Admission counts every slot already promised (queued or still in the core),
    // so the FIFO cannot overflow and in_ready never depends on out_ready.
    assign occupancy    = 32'(count_q) + inflight;
    assign bus.in_ready = !rst && (occupancy < 32'(DEPTH));
    assign accept       = bus.in_valid && bus.in_ready;

    assign MR = accept ? bus.in_mr : '0;
    assign MC = accept ? bus.in_mc : '0;

    generate
        for (genvar gi = 0; gi < LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign vld_d[gi] = accept;
                assign tag_d[gi] = accept ? bus.in_tag : '0;
            end else begin : g_shift
                assign vld_d[gi] = vld_q[gi-1];
                assign tag_d[gi] = tag_q[gi-1];
            end
        end
    endgenerate

    assign wr_en         = vld_q[LAT-1];
    assign bus.out_valid = (count_q != '0);
    assign pop           = bus.out_valid && bus.out_ready;
    assign busy          = (inflight != '0) || bus.out_valid;

    // Head is gated by occupancy so outputs read zero while empty or in reset.
    assign {bus.out_prod, bus.out_tag} = bus.out_valid ? mem[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {Prod, tag_q[LAT-1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(wr_en && !pop && count_q == CW'(DEPTH)))
                else $error("mult_stream_ctrl: write into full result queue");
        end
    end
endmodule

// File: tb/tb_mult_stream_ctrl.sv
// Directed bench for mult_stream_ctrl with a two-stage multiplier core model.
module tb_mult_stream_ctrl;
    localparam int WIDTH = 32;
    localparam int TAGW  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [WIDTH-1:0]  MR, MC;
    logic [63:0]       Prod;
    logic              busy;

    logic [63:0]       p1_q = '0;
    logic [63:0]       p2_q = '0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [67:0] exp_q [$];
    logic [67:0] obs_q [$];
    int          obs_cyc [$];

    mult_stream_ctrl_if #(.WIDTH(WIDTH), .TAGW(TAGW)) bus ();

    mult_stream_ctrl #(.WIDTH(WIDTH), .LAT(2), .DEPTH(4), .TAGW(TAGW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .MR   (MR),
        .MC   (MC),
        .Prod (Prod),
        .busy (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        p1_q <= 64'(MR) * 64'(MC);
        p2_q <= p1_q;
        cyc  <= cyc + 1;
    end
    assign Prod = p2_q;

    always @(negedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready)
            exp_q.push_back({64'(bus.in_mr) * 64'(bus.in_mc), bus.in_tag});
        if (!rst && bus.out_valid && bus.out_ready) begin
            obs_q.push_back({bus.out_prod, bus.out_tag});
            obs_cyc.push_back(cyc);
            $display("[TB] pop cycle=%0d prod=%h tag=%h", cyc, bus.out_prod, bus.out_tag);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int n = 0;
        while (busy !== 1'b0 && n < max_cycles) begin
            step();
            n++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic drive(input logic [31:0] mr, input logic [31:0] mc, input logic [3:0] tag);
        bus.in_valid = 1'b1;
        bus.in_mr    = mr;
        bus.in_mc    = mc;
        bus.in_tag   = tag;
    endtask

    task automatic compare_streams(input string tag);
        int n;
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_prod"}, obs_q[i][67:4], exp_q[i][67:4]);
            check({tag, "_tag"}, 64'(obs_q[i][3:0]), 64'(exp_q[i][3:0]));
        end
        obs_q.delete();
        exp_q.delete();
        obs_cyc.delete();
    endtask

    initial begin
        int acc;
        int k;
        int n;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_mr     = '0;
        bus.in_mc     = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_prod", bus.out_prod, 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", 64'(bus.in_ready), 64'd1);

        // Single operation: 3*5 tag 1
        bus.out_ready = 1'b1;
        drive(32'd3, 32'd5, 4'd1);
        #1;
        check("single_MR", 64'(MR), 64'd3);
        check("single_MC", 64'(MC), 64'd5);
        step();
        bus.in_valid = 1'b0;
        #1;
        check("idle_MR", 64'(MR), 64'd0);
        check("idle_MC", 64'(MC), 64'd0);
        step();
        step();
        check("single_valid", 64'(bus.out_valid), 64'd1);
        check("single_prod", bus.out_prod, 64'd15);
        check("single_tag", 64'(bus.out_tag), 64'd1);
        step();
        check("single_busy", 64'(busy), 64'd0);
        compare_streams("single");

        // Back-to-back stream of 8
        for (int i = 0; i < 8; i++) begin
            drive(32'(i + 2), 32'(7 * i + 1), 4'(i));
            #1;
            check("b2b_ready", 64'(bus.in_ready), 64'd1);
            step();
        end
        bus.in_valid = 1'b0;
        wait_idle("b2b_idle", 20);
        check("b2b_n", 64'(obs_q.size()), 64'd8);
        if (obs_q.size() == 8) begin
            check("b2b_spacing", 64'(obs_cyc[7] - obs_cyc[0]), 64'd7);
            check("b2b_first", 64'(obs_q[0]), {4'd0, 64'd2, 4'd0});
            check("b2b_last_prod", obs_q[7][67:4], 64'd450);
            check("b2b_last_tag", 64'(obs_q[7][3:0]), 64'd7);
        end
        compare_streams("b2b");

        // Backpressure: only DEPTH accepts while the consumer stalls
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            drive(32'(100 + i - acc + acc), 32'd3, 4'(i));
            bus.in_mr = 32'(100 + acc);
            bus.in_tag = 4'(acc);
            #1;
            if (bus.in_ready) acc++;
            step();
        end
        bus.in_valid = 1'b0;
        #1;
        check("bp_accepts", 64'(acc), 64'd4);
        check("bp_ready_low", 64'(bus.in_ready), 64'd0);
        check("bp_full_busy", 64'(busy), 64'd1);
        bus.out_ready = 1'b1;
        #1;
        check("bp_ready_at_pop", 64'(bus.in_ready), 64'd0);
        step();
        bus.out_ready = 1'b0;
        #1;
        check("bp_ready_after_pop", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        wait_idle("bp_idle", 20);
        check("bp_n", 64'(obs_q.size()), 64'd4);
        if (obs_q.size() == 4) begin
            check("bp_first_prod", obs_q[0][67:4], 64'd300);
            check("bp_last_prod", obs_q[3][67:4], 64'd309);
            check("bp_last_tag", 64'(obs_q[3][3:0]), 64'd3);
        end
        compare_streams("bp");

        // Simultaneous push and pop with one entry queued
        bus.out_ready = 1'b0;
        drive(32'd7, 32'd9, 4'd5);
        step();
        drive(32'd11, 32'd13, 4'd6);
        step();
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 1'b1;
        #1;
        check("pp_head_a", bus.out_prod, 64'd63);
        step();
        bus.out_ready = 1'b0;
        #1;
        check("pp_valid", 64'(bus.out_valid), 64'd1);
        check("pp_head_b", bus.out_prod, 64'd143);
        check("pp_tag_b", 64'(bus.out_tag), 64'd6);
        step();
        check("pp_still_one", 64'(bus.out_valid), 64'd1);
        check("pp_hold_b", bus.out_prod, 64'd143);
        bus.out_ready = 1'b1;
        step();
        check("pp_empty", 64'(bus.out_valid), 64'd0);
        wait_idle("pp_idle", 10);
        compare_streams("pp");

        // Pointer wrap over 16 operations with a stalling consumer
        k = 0;
        n = 0;
        while (k < 16 && n < 300) begin
            drive(32'h1000_0000 + 32'(k) * 32'h0123_4567, 32'(k * k + 3), 4'(k));
            bus.out_ready = (n % 4 != 3);
            #1;
            if (bus.in_ready) k++;
            step();
            n++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("wrap_accepts", 64'(k), 64'd16);
        wait_idle("wrap_idle", 30);
        compare_streams("wrap");

        // Reset with two in flight and two queued
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(32'(20 + i), 32'd2, 4'(i));
            step();
        end
        bus.in_valid = 1'b0;
        #1;
        check("mid_ready_low", 64'(bus.in_ready), 64'd0);
        check("mid_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ready", 64'(bus.in_ready), 64'd0);
        check("mid_rst_prod", bus.out_prod, 64'd0);
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
        step();
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("mid_rel_ready", 64'(bus.in_ready), 64'd1);
        repeat (6) step();
        check("mid_no_stale", 64'(obs_q.size()), 64'd0);
        check("mid_idle_busy", 64'(busy), 64'd0);

        // Next op after reset, then the all-ones by MSB corner
        drive(32'd6, 32'd7, 4'd9);
        step();
        drive(32'hFFFF_FFFF, 32'h8000_0000, 4'hA);
        step();
        bus.in_valid = 1'b0;
        wait_idle("post_idle", 20);
        check("post_n", 64'(obs_q.size()), 64'd2);
        if (obs_q.size() == 2) begin
            check("post_prod", obs_q[0][67:4], 64'd42);
            check("post_tag", 64'(obs_q[0][3:0]), 64'd9);
            check("corner_prod", obs_q[1][67:4], 64'h7FFF_FFFF_8000_0000);
            check("corner_tag", 64'(obs_q[1][3:0]), 64'hA);
        end
        compare_streams("post");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
